pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch stage of the single-cycle CPU; owns the PC, the instruction register, the next-PC selection and the halt state.
- Issues word reads to instruction memory through a req/ack handshake and presents one instruction per execute slot to the control unit and register file.
- Consumes the control unit's PCWre, the decoded beq indication and the ALU zero flag to pick the next PC at the end of each execute slot.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request to instruction memory; held until acknowledged.
- imem_addr  out  32  byte address of the read; always equals pc.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- imem_ack  in  1  read complete; may assert in the first imem_req cycle.
- PCWre  in  1  from control unit; 0 means halt.
- Branch  in  1  high for beq (opcode 6'b110000).
- zero  in  1  ALU zero flag, valid during the execute slot.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26], feeds the control unit.
- instr_valid  out  1  high for exactly one cycle per fetched instruction (execute slot).
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, combinational.
- halted  out  1  high in HALTED.
- retired_cnt  out  CNT_W  count of completed execute slots.

Behaviour:
- Reset (async, immediate) sets state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, retired_cnt=0.
- Reset asserted mid-transaction drops imem_req immediately. A late imem_ack after reset is ignored.
- FSM states: IDLE, REQ, EXEC, HALTED.
- IDLE: imem_req=0. Next state is REQ unconditionally; this gives one settle cycle after reset release.
- REQ: imem_req=1. On imem_ack=1, instr <= imem_rdata and next state is EXEC; otherwise stay in REQ.
- EXEC: instr_valid=1 and imem_req=0. Control signals are decoded combinationally from opcode. The next-PC decision is made at the clock edge that leaves EXEC:
  - PCWre=0: pc is unchanged, halted <= 1, next state HALTED.
  - PCWre=1 and Branch=1 and zero=1: pc <= pc + 4 + (sign_extend(instr[15:0]) << 2); next state REQ.
  - Otherwise: pc <= pc + 4; next state REQ.
  - retired_cnt increments by 1 in every EXEC, including the halt instruction.
- HALTED: terminal until Reset. imem_req=0, instr_valid=0, pc and instr frozen, imem_ack ignored.
- imem_ack outside REQ is ignored; instr is not updated.
- All PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0, and backward branch offsets use two's complement. pc[1:0] is always 0.
- retired_cnt wraps from all-ones to 0.
- Throughput: at least 2 cycles per instruction (REQ with same-cycle ack, then EXEC); each extra ack-wait cycle adds 1.
- Branch and zero are don't-care outside EXEC.

Decomposition:
- Shared package cpu_defs_pkg holds the opcode constants (OP_ADD=6'b000000, OP_BEQ=6'b110000, OP_HALT=6'b111111, ...), the fetch state encoding and the instruction field bit positions.
- Sub-module pc_next_calc: purely combinational; inputs pc, imm16, take_branch; outputs pc_plus4 and next_pc.

Test Plan:
- Reset release with ack tied high: imem_addr sequence is 0x0, 0x4, 0x8. instr_valid pulses every 2nd cycle starting on the 3rd cycle after reset release. retired_cnt reaches 3 after the 3rd EXEC.
- beq at pc=0x10 with imm16=16'h0003 and zero=1: next imem_addr=0x20. Same instruction with zero=0: next imem_addr=0x14.
- Backward branch at pc=0x20 with imm16=16'hFFFE and zero=1: next pc=0x1C.
- imem_ack delayed by 3 cycles: imem_req held high for 4 cycles, imem_addr stable throughout, exactly one instr_valid pulse carrying the delivered word.
- PCWre=0 in EXEC at pc=0x30: halted=1 the next cycle, pc stays 0x30, no further imem_req, retired_cnt incremented once. A spurious imem_ack causes no change.
- Reset asserted while in REQ: imem_req falls in the same cycle, pc=RESET_PC, and fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU opcodes, fetch state encoding and instruction field positions
package cpu_defs_pkg;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_LW   = 6'b100111;
   localparam logic [5:0] OP_SW   = 6'b100110;
   localparam logic [5:0] OP_BEQ  = 6'b110000;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational sequential/branch next-PC computation
module pc_next_calc (
   input  logic [31:0] pc_i,
   input  logic [15:0] imm16_i,
   input  logic        take_branch_i,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] next_pc_o
);

   logic [31:0] br_off;

   // Word offset relative to pc+4; all arithmetic wraps modulo 2^32.
   assign br_off     = {{14{imm16_i[15]}}, imm16_i, 2'b00};
   assign pc_plus4_o = pc_i + 32'd4;
   assign next_pc_o  = take_branch_i ? (pc_plus4_o + br_off) : pc_plus4_o;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch stage: PC, instruction register, next-PC selection and halt
module pc_fetch_unit
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ack,
   input  logic             PCWre,
   input  logic             Branch,
   input  logic             zero,
   output logic [31:0]      instr,
   output logic [5:0]       opcode,
   output logic             instr_valid,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             halted,
   output logic [CNT_W-1:0] retired_cnt
);

   fetch_state_e     state_q;
   logic [31:0]      pc_q;
   logic [31:0]      pc_d;
   logic [31:0]      instr_q;
   logic             req_q;
   logic             valid_q;
   logic             halted_q;
   logic [CNT_W-1:0] cnt_q;
   logic             take_branch;

   assign take_branch = (state_q == ST_EXEC) && PCWre && Branch && zero;

   pc_next_calc u_pc_next_calc (
      .pc_i          (pc_q),
      .imm16_i       (instr_q[IMM_MSB:IMM_LSB]),
      .take_branch_i (take_branch),
      .pc_plus4_o    (pc_plus4),
      .next_pc_o     (pc_d)
   );

   // Outputs are registered alongside the state so each is valid for the whole state.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= 32'h0000_0000;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_REQ;
               req_q   <= 1'b1;
            end
            ST_REQ: begin
               if (imem_ack) begin
                  instr_q <= imem_rdata;
                  state_q <= ST_EXEC;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
               end
            end
            ST_EXEC: begin
               valid_q <= 1'b0;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (!PCWre) begin
                  halted_q <= 1'b1;
                  state_q  <= ST_HALTED;
               end else begin
                  pc_q    <= pc_d;
                  state_q <= ST_REQ;
                  req_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_HALTED;
            end
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[OPC_MSB:OPC_LSB];
   assign instr_valid = valid_q;
   assign halted      = halted_q;
   assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
   import cpu_defs_pkg::*;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        PCWre;
   logic        Branch;
   logic        zero;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        halted;
   logic [31:0] retired_cnt;

   logic [31:0] mem [0:15];
   int n_tests = 0;
   int n_fail  = 0;

   assign imem_rdata = mem[imem_addr[5:2]];
   assign PCWre      = (opcode != OP_HALT);
   assign Branch     = (opcode == OP_BEQ);

   always #5 CLK = ~CLK;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ack    (imem_ack),
      .PCWre       (PCWre),
      .Branch      (Branch),
      .zero        (zero),
      .instr       (instr),
      .opcode      (opcode),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .halted      (halted),
      .retired_cnt (retired_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic wait_exec(input logic [31:0] exp_pc);
      for (int i = 0; i < 20 && !instr_valid; i++) step();
      check("exec_reached", {31'd0, instr_valid}, 32'd1);
      check("exec_pc", pc, exp_pc);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0000_1000 + i;
      mem[4]  = 32'hC000_0003;
      mem[8]  = 32'hC000_FFFE;
      mem[9]  = 32'h0123_4567;
      mem[12] = 32'hFC00_0000;
      imem_ack = 1'b1;
      zero     = 1'b0;

      repeat (2) step();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_cnt", retired_cnt, 32'd0);
      check("rst_plus4", pc_plus4, 32'h4);
      Reset = 1'b0;

      for (int k = 1; k <= 6; k++) begin
         step();
         check("seq_req", {31'd0, imem_req}, (k % 2 == 1) ? 32'd1 : 32'd0);
         check("seq_valid", {31'd0, instr_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
         check("seq_addr", imem_addr, 32'(4 * ((k - 1) / 2)));
      end
      step();
      check("seq_cnt3", retired_cnt, 32'd3);
      check("seq_addr_c", imem_addr, 32'hC);

      wait_exec(32'hC);
      zero = 1'b1;
      step();
      wait_exec(32'h10);
      check("beq_opcode", {26'd0, opcode}, {26'd0, OP_BEQ});
      step();
      check("beq_taken_addr", imem_addr, 32'h20);
      wait_exec(32'h20);
      step();
      check("beq_back_addr", imem_addr, 32'h1C);
      wait_exec(32'h1C);
      zero = 1'b0;
      step();
      wait_exec(32'h20);
      imem_ack = 1'b0;
      step();
      check("beq_nt_addr", imem_addr, 32'h24);

      for (int c = 0; c < 4; c++) begin
         check("wait_req", {31'd0, imem_req}, 32'd1);
         check("wait_addr", imem_addr, 32'h24);
         check("wait_valid", {31'd0, instr_valid}, 32'd0);
         if (c == 3) imem_ack = 1'b1;
         else step();
      end
      step();
      check("wait_exec_valid", {31'd0, instr_valid}, 32'd1);
      check("wait_instr", instr, 32'h0123_4567);
      step();
      check("wait_one_pulse", {31'd0, instr_valid}, 32'd0);
      check("wait_next_addr", imem_addr, 32'h28);

      wait_exec(32'h28);
      step();
      wait_exec(32'h2C);
      step();
      wait_exec(32'h30);
      check("halt_opcode", {26'd0, opcode}, {26'd0, OP_HALT});
      check("halt_cnt_before", retired_cnt, 32'd11);
      step();
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_pc", pc, 32'h30);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_valid", {31'd0, instr_valid}, 32'd0);
      check("halt_cnt", retired_cnt, 32'd12);
      mem[12] = 32'hDEAD_BEEF;
      repeat (3) step();
      check("spur_instr", instr, 32'hFC00_0000);
      check("spur_halted", {31'd0, halted}, 32'd1);
      check("spur_req", {31'd0, imem_req}, 32'd0);
      check("spur_pc", pc, 32'h30);
      check("spur_cnt", retired_cnt, 32'd12);

      Reset = 1'b1;
      step();
      Reset = 1'b0;
      imem_ack = 1'b0;
      step();
      check("rreq_req", {31'd0, imem_req}, 32'd1);
      step();
      check("rreq_hold", {31'd0, imem_req}, 32'd1);
      Reset = 1'b1;
      #1;
      check("rreq_async_req", {31'd0, imem_req}, 32'd0);
      check("rreq_async_pc", pc, 32'h0);
      check("rreq_async_halted", {31'd0, halted}, 32'd0);
      check("rreq_async_cnt", retired_cnt, 32'd0);
      imem_ack = 1'b1;
      step();
      Reset = 1'b0;
      check("rreq_idle_req", {31'd0, imem_req}, 32'd0);
      step();
      check("rreq_restart_req", {31'd0, imem_req}, 32'd1);
      check("rreq_restart_addr", imem_addr, 32'h0);
      check("rreq_restart_valid", {31'd0, instr_valid}, 32'd0);
      zero = 1'b0;
      for (int j = 0; j < 4; j++) begin
         wait_exec(32'(4 * j));
         step();
      end
      wait_exec(32'h10);
      step();
      check("beq_zero0_addr", imem_addr, 32'h14);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
